// File: rtl/dds_pkg.sv
// Shared definitions for the AD9850 frame writer: register map, frame width and FSM states.
package dds_pkg;

    localparam int DDS_FRAME_W   = 40;
    localparam int DDS_NUM_BYTES = 5;

    localparam logic [7:0] DDS_ADDR_FTW0   = 8'h00;
    localparam logic [7:0] DDS_ADDR_FTW1   = 8'h01;
    localparam logic [7:0] DDS_ADDR_FTW2   = 8'h02;
    localparam logic [7:0] DDS_ADDR_FTW3   = 8'h03;
    localparam logic [7:0] DDS_ADDR_CTRL   = 8'h04;
    localparam logic [7:0] DDS_ADDR_COMMIT = 8'h05;

    typedef enum logic [2:0] {
        ST_INIT_RST  = 3'd0,
        ST_INIT_WCLK = 3'd1,
        ST_INIT_FQ   = 3'd2,
        ST_IDLE      = 3'd3,
        ST_LOAD      = 3'd4,
        ST_SHIFT_LO  = 3'd5,
        ST_SHIFT_HI  = 3'd6,
        ST_FQ        = 3'd7
    } dds_wr_state_t;

    function automatic int dds_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dds_shadow_regs.sv
// Address latch, five-byte shadow of the AD9850 control word, address decode and commit/error strobes.
// Optional feature macro: DDS_AUTO_COMMIT_EN (a write to the FTW MSB also commits).
module dds_shadow_regs
    import dds_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             addr_data,
    input  logic                   addr_data_valid,
    input  logic [7:0]             cmd_data,
    input  logic                   cmd_data_valid,
    output logic [DDS_FRAME_W-1:0] frame,
    output logic                   commit,
    output logic                   bad_addr
);

    logic [7:0]                          cur_addr_r;
    logic [DDS_NUM_BYTES-1:0][7:0]       shadow_r;
    logic [7:0]                          eff_addr_s;
    logic                                shadow_wr_s;

    // A same-cycle address strobe takes effect before the data write
    always_comb begin
        eff_addr_s = cur_addr_r;
        if (addr_data_valid) begin
            eff_addr_s = addr_data;
        end else begin
            eff_addr_s = cur_addr_r;
        end
    end

    // Decode the effective address into shadow write, commit and error strobes
    always_comb begin
        shadow_wr_s = 1'b0;
        commit      = 1'b0;
        bad_addr    = 1'b0;
        case (eff_addr_s)
            DDS_ADDR_FTW0, DDS_ADDR_FTW1, DDS_ADDR_FTW2, DDS_ADDR_CTRL: begin
                shadow_wr_s = cmd_data_valid;
            end
            DDS_ADDR_FTW3: begin
                shadow_wr_s = cmd_data_valid;
`ifdef DDS_AUTO_COMMIT_EN
                commit      = cmd_data_valid;
`else
                commit      = 1'b0;
`endif
            end
            DDS_ADDR_COMMIT: begin
                commit = cmd_data_valid;
            end
            default: begin
                bad_addr = cmd_data_valid;
            end
        endcase
    end

    // Address latch and shadow byte storage
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr_r <= 8'h00;
            shadow_r   <= '0;
        end else begin
            if (addr_data_valid) begin
                cur_addr_r <= addr_data;
            end
            if (shadow_wr_s) begin
                shadow_r[eff_addr_s[2:0]] <= cmd_data;
            end
        end
    end

    assign frame = shadow_r;

endmodule

// File: rtl/dds_frame_writer.sv
// AD9850 serial frame writer: runs the serial-mode entry sequence after reset, then shifts
// committed 40-bit shadow words LSB-first on W_CLK/DATA and pulses FQ_UD.
// Optional feature macro: DDS_AUTO_COMMIT_EN (handled in dds_shadow_regs).
module dds_frame_writer
    import dds_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int FQ_UD_CYCLES = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] addr_data,
    input  logic       addr_data_valid,
    input  logic [7:0] cmd_data,
    input  logic       cmd_data_valid,
    output logic       busy,
    output logic       err_pulse,
    output logic       dds_reset,
    output logic       dds_w_clk,
    output logic       dds_fq_ud,
    output logic       dds_data
);

    localparam int CNT_W = $clog2(dds_max(CLK_DIV, FQ_UD_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] FQ_LAST  = CNT_W'(FQ_UD_CYCLES - 1);
    // The reset cycle itself is the INIT_RST entry cycle, so this state counts one further
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(FQ_UD_CYCLES);
    localparam logic [5:0]       LAST_BIT = 6'(DDS_FRAME_W - 1);

    dds_wr_state_t          state_r, next_state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_next_s;
    logic [5:0]             bit_r, bit_next_s;
    logic [DDS_FRAME_W-1:0] shift_r, shift_next_s;
    logic                   pend_r, pend_next_s;
    logic                   drop_s;
    logic                   data_next_s;
    logic [DDS_FRAME_W-1:0] frame_s;
    logic                   commit_s;
    logic                   bad_addr_s;

    dds_shadow_regs u_shadow (
        .clk             (clk_in),
        .rst             (rst_in),
        .addr_data       (addr_data),
        .addr_data_valid (addr_data_valid),
        .cmd_data        (cmd_data),
        .cmd_data_valid  (cmd_data_valid),
        .frame           (frame_s),
        .commit          (commit_s),
        .bad_addr        (bad_addr_s)
    );

    // Next-state, counters, shift register and one-deep commit queue
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        bit_next_s   = bit_r;
        shift_next_s = shift_r;
        pend_next_s  = pend_r;
        drop_s       = 1'b0;
        data_next_s  = dds_data;

        if (state_r == ST_IDLE) begin
            // A pending commit is consumed here; a commit arriving now re-fills the slot
            pend_next_s = pend_r & commit_s;
        end else if (commit_s) begin
            if (pend_r) begin
                drop_s = 1'b1;
            end else begin
                pend_next_s = 1'b1;
            end
        end else begin
            pend_next_s = pend_r;
        end

        case (state_r)
            ST_INIT_RST: begin
                if (cnt_r == RST_LAST) begin
                    next_state_s = ST_INIT_WCLK;
                    cnt_next_s   = '0;
                end else begin
                    next_state_s = ST_INIT_RST;
                end
            end
            ST_INIT_WCLK: begin
                if (cnt_r == DIV_LAST) begin
                    next_state_s = ST_INIT_FQ;
                    cnt_next_s   = '0;
                end else begin
                    next_state_s = ST_INIT_WCLK;
                end
            end
            ST_INIT_FQ: begin
                if (cnt_r == FQ_LAST) begin
                    next_state_s = ST_IDLE;
                    cnt_next_s   = '0;
                end else begin
                    next_state_s = ST_INIT_FQ;
                end
            end
            ST_IDLE: begin
                cnt_next_s = '0;
                if (commit_s || pend_r) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                shift_next_s = frame_s;
                bit_next_s   = 6'd0;
                cnt_next_s   = '0;
                next_state_s = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (cnt_r == DIV_LAST) begin
                    next_state_s = ST_SHIFT_HI;
                    cnt_next_s   = '0;
                end else begin
                    next_state_s = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_HI: begin
                if (cnt_r == DIV_LAST) begin
                    shift_next_s = {1'b0, shift_r[DDS_FRAME_W-1:1]};
                    bit_next_s   = bit_r + 6'd1;
                    cnt_next_s   = '0;
                    if (bit_r == LAST_BIT) begin
                        next_state_s = ST_FQ;
                    end else begin
                        next_state_s = ST_SHIFT_LO;
                    end
                end else begin
                    next_state_s = ST_SHIFT_HI;
                end
            end
            ST_FQ: begin
                if (cnt_r == FQ_LAST) begin
                    next_state_s = ST_IDLE;
                    cnt_next_s   = '0;
                end else begin
                    next_state_s = ST_FQ;
                end
            end
            default: begin
                next_state_s = ST_INIT_RST;
                cnt_next_s   = '0;
            end
        endcase

        // Data only moves while W_CLK is low, so it is stable across the whole high phase
        if (next_state_s == ST_SHIFT_LO) begin
            data_next_s = shift_next_s[0];
        end else begin
            data_next_s = dds_data;
        end
    end

    // State, datapath and pin registers; pins are decoded from the state being entered
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r   <= ST_INIT_RST;
            cnt_r     <= '0;
            bit_r     <= 6'd0;
            shift_r   <= '0;
            pend_r    <= 1'b0;
            busy      <= 1'b1;
            err_pulse <= 1'b0;
            dds_reset <= 1'b0;
            dds_w_clk <= 1'b0;
            dds_fq_ud <= 1'b0;
            dds_data  <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            cnt_r     <= cnt_next_s;
            bit_r     <= bit_next_s;
            shift_r   <= shift_next_s;
            pend_r    <= pend_next_s;
            busy      <= (next_state_s != ST_IDLE) || pend_next_s;
            err_pulse <= bad_addr_s || drop_s;
            dds_reset <= (next_state_s == ST_INIT_RST);
            dds_w_clk <= (next_state_s == ST_INIT_WCLK) || (next_state_s == ST_SHIFT_HI);
            dds_fq_ud <= (next_state_s == ST_INIT_FQ) || (next_state_s == ST_FQ);
            dds_data  <= data_next_s;
        end
    end

endmodule

// File: doc/dds_frame_writer.md
# dds_frame_writer

Downstream consumer of the UART receive decoder's `addr_data`/`cmd_data` strobes. It holds a shadow copy of the AD9850 40-bit control word, written one byte at a time. A commit serialises the word LSB-first onto the DDS W_CLK/DATA pins, then pulses FQ_UD. After reset it also runs the AD9850 serial-mode entry sequence.

## Interface
- `CLK_DIV`, 4, clk_in cycles per W_CLK half-period (≥1)
- `FQ_UD_CYCLES`, 4, width in cycles of the DDS_RESET and FQ_UD pulses (≥1)
- `clk_in` in 1: the block's only clock; all logic on the rising edge
- `rst_in` in 1: reset, synchronous, active-high
- `addr_data` in 8: register address byte from the decoder
- `addr_data_valid` in 1: one-cycle strobe qualifying `addr_data`
- `cmd_data` in 8: data byte from the decoder
- `cmd_data_valid` in 1: one-cycle strobe qualifying `cmd_data`
- `busy` out 1: high during init or while a frame is in progress
- `err_pulse` out 1: one-cycle pulse on an invalid address or a dropped commit
- `dds_reset` out 1: AD9850 RESET pin
- `dds_w_clk` out 1: AD9850 W_CLK pin
- `dds_fq_ud` out 1: AD9850 FQ_UD pin
- `dds_data` out 1: AD9850 D7 serial data pin

## Operation
- **Address latch.**
  - `addr_data_valid` loads `cur_addr`.
  - `cmd_data_valid` writes `cmd_data` to `shadow[cur_addr]`.
  - If both strobes arrive in the same cycle, the new address is applied first and the data is written to it.
- **Address map.**
  - 0x00–0x03: frequency tuning word, bytes 0–3 (LSB byte at 0x00), frame bits 31:0.
  - 0x04: phase/control byte, frame bits 39:32.
  - 0x05: commit; the data value is ignored.
  - 0x06–0xFF: a write pulses `err_pulse` and leaves the shadow unchanged.
- **Shadow writes during busy.** Allowed. The frame was snapshotted into the shift register at LOAD.
- **Commit queue.**
  - A commit while busy sets `commit_pend`, one deep.
  - A further commit while `commit_pend` is already set is dropped and pulses `err_pulse`.
- **FSM states:** INIT_RST → INIT_WCLK → INIT_FQ → IDLE → LOAD → SHIFT_LO ⇄ SHIFT_HI → FQ → IDLE.
  - INIT_RST: `dds_reset`=1 for FQ_UD_CYCLES cycles.
  - INIT_WCLK: `dds_w_clk`=1 for CLK_DIV cycles.
  - INIT_FQ: `dds_fq_ud`=1 for FQ_UD_CYCLES cycles. This enters serial mode.
  - IDLE: go to LOAD on a commit or on `commit_pend`; clear `commit_pend` on that transition.
  - LOAD: copy the 40-bit shadow into the shift register and clear the bit counter.
  - SHIFT_LO: `dds_data` = shift[0] and `w_clk`=0 for CLK_DIV cycles.
  - SHIFT_HI: `w_clk`=1 for CLK_DIV cycles, then shift right and increment the bit counter. After bit 39, go to FQ; otherwise go to SHIFT_LO.
  - FQ: `fq_ud`=1 for FQ_UD_CYCLES cycles, then go to IDLE.
- **Counter widths.** Bit counter is 6 bits. The cycle counter is `$clog2(max(CLK_DIV,FQ_UD_CYCLES))+1` bits.

## Timing
- **While `rst_in` is high:**
  - All pin outputs are 0.
  - `err_pulse`=0 and `busy`=1.
  - Shadow is cleared to 0; `cur_addr`=0; `commit_pend`=0.
  - State is INIT_RST.
- **Init duration.** The first cycle after reset release is the first INIT_RST cycle. Init lasts `2*FQ_UD_CYCLES+CLK_DIV` cycles (12 at defaults). `busy` falls in the cycle after init ends.
- **Commit latency.**
  - A commit write in cycle t (IDLE) puts the FSM in LOAD at t+1.
  - `busy` is high from t+1 for exactly `1+80*CLK_DIV+FQ_UD_CYCLES` cycles (325 at defaults).
  - `dds_data` is stable for the whole W_CLK high phase and changes only in SHIFT_LO.
- **Queued commit.** LOAD starts one cycle after `busy` would fall. `busy` stays high continuously between the two frames.
- **Commit during init.** Sets `commit_pend`; the frame runs right after init.
- **`err_pulse`** appears in the cycle after the offending strobe.
- **Reset mid-frame.** Outputs go to 0 on the next edge. The frame is abandoned and init restarts.

## Configuration
- **`DDS_AUTO_COMMIT_EN` defined:** a write to 0x03 (FTW MSB) also acts as a commit, queued or dropped under the same rules. A same-cycle write to 0x03 counts as one commit.
- **Not defined:** only address 0x05 commits.

## Structure
- Shared package `dds_pkg`:
  - Address constants `DDS_ADDR_FTW0..3`, `DDS_ADDR_CTRL`, `DDS_ADDR_COMMIT`.
  - `DDS_FRAME_W`=40.
  - FSM state enum type `dds_wr_state_t`.
- Sub-module `dds_shadow_regs`: address latch, five-byte register file, address decode, and commit/error strobes. The top level holds the FSM, counters and shift register.

## Test plan
- **Reset release.** Required response:
  - `dds_reset` high for cycles 1–4, then `w_clk` high for 5–8, then `fq_ud` high for 9–12.
  - `busy` falls at cycle 13.
  - No other pin toggles.
- **Single frame.** Stimulus: write 0x78, 0x56, 0x34, 0x12, 0x00 to 0x00–0x04, then commit via 0x05. Required response:
  - 40 `w_clk` rising edges sampling `dds_data` LSB-first reassemble 0x0012345678.
  - `fq_ud` is high for 4 cycles after the last edge.
  - `busy` is high for 325 cycles.
- **Queued and dropped commits.** Stimulus: three commits during one frame. Required response:
  - A second frame starts with `busy` never dropping.
  - The third commit gives one `err_pulse`.
  - No third frame is sent.
- **Invalid address.** Stimulus: address 0x06 then data 0xAA. Required response: `err_pulse` once; a following commit sends the unchanged shadow word.
- **Simultaneous strobes.** Stimulus: `addr_data`=0x04 and `cmd_data`=0xFC valid in the same cycle. Required response: frame bits 39:32 = 0xFC.
- **Reset mid-frame.** Stimulus: assert `rst_in` after bit 20. Required response:
  - Pins go to 0 on the next cycle.
  - The init sequence repeats.
  - A subsequent commit sends 0x0000000000.
